// File: rtl/ksz_bus_pkg.sv
// Shared types and register map for the KSZ-style bus responder.
// Register byte addresses; word index is the byte address shifted right by one.
package ksz_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMDW = 2'd1,
    ST_DATW = 2'd2,
    ST_DATR = 2'd3
  } state_t;

  localparam logic [15:0] CHIP_ID = 16'h8872;

  localparam logic [7:0] MARL   = 8'h10;
  localparam logic [7:0] MARM   = 8'h12;
  localparam logic [7:0] MARH   = 8'h14;
  localparam logic [7:0] TXCR   = 8'h70;
  localparam logic [7:0] RXCR1  = 8'h74;
  localparam logic [7:0] RXCR2  = 8'h76;
  localparam logic [7:0] RXQCR  = 8'h82;
  localparam logic [7:0] RXFDPR = 8'h86;
  localparam logic [7:0] IER    = 8'h90;
  localparam logic [7:0] ISR    = 8'h92;
  localparam logic [7:0] RXFCTR = 8'h9C;
  localparam logic [7:0] CIDER  = 8'hC0;
  localparam logic [7:0] P1CR   = 8'hF6;

  function automatic logic [6:0] word_of(input logic [7:0] b);
    return b[7:1];
  endfunction

endpackage

// File: rtl/ksz_resp_regfile.sv
// 128-word register storage with read-only CIDER and W1C ISR.
// ISR takes irqSet every cycle; a coincident clear loses to set.
module ksz_resp_regfile
  import ksz_bus_pkg::*;
(
  input  logic        clk40m,
  input  logic        reset,
  input  logic        i_we,
  input  logic [6:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [6:0]  i_raddr,
  output logic [15:0] o_rdata,
  input  logic [15:0] i_irq_set,
  output logic        o_intrn
);

  localparam logic [6:0] W_CIDER = word_of(CIDER);
  localparam logic [6:0] W_ISR   = word_of(ISR);
  localparam logic [6:0] W_IER   = word_of(IER);

  logic [15:0] r_mem [128];
  logic [15:0] w_clr;
  logic        w_plain_we;

  assign w_clr = (i_we && i_waddr == W_ISR) ? i_wdata : 16'h0000;
  assign w_plain_we = i_we && (i_waddr != W_CIDER)
                      && (i_waddr != W_ISR);

  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) r_mem[i] <= 16'h0000;
    end else begin
      if (w_plain_we) r_mem[i_waddr] <= i_wdata;
      r_mem[W_ISR] <= (r_mem[W_ISR] & ~w_clr) | i_irq_set;
    end
  end

  assign o_rdata = (i_raddr == W_CIDER) ? CHIP_ID : r_mem[i_raddr];
  assign o_intrn = ~|(r_mem[W_ISR] & r_mem[W_IER]);

endmodule

// File: rtl/ksz_bus_responder.sv
// Bus responder: command/data strobe FSM in front of the register file.
// Define KSZ_RESP_STRICT_BE_EN to reject commands with unpaired byte enables.
module ksz_bus_responder
  import ksz_bus_pkg::*;
(
  input  logic        clk40m,
  input  logic        reset,
  input  logic        CMD,
  input  logic        WRN,
  input  logic        RDN,
  input  logic [15:0] SDIn,
  output logic [15:0] SDOut,
  output logic        SDOe,
  input  logic [15:0] irqSet,
  output logic        INTRN,
  output logic        busErr
);

  state_t      r_state;
  logic [15:0] r_cap;
  logic [6:0]  r_addr;
  logic        r_addr_valid;
  logic        r_drop;
  logic        w_we;
  logic        w_proto_err;
  logic        w_cmd_ok;
  logic [15:0] w_rdata;

  assign w_proto_err = (~WRN & ~RDN) | (~RDN & CMD);
  assign w_we = (r_state == ST_DATW) & WRN & ~r_drop;

`ifdef KSZ_RESP_STRICT_BE_EN
  assign w_cmd_ok = ((r_cap[15:12] == 4'h3) & ~r_cap[1])
                  | ((r_cap[15:12] == 4'hC) & r_cap[1]);
`else
  assign w_cmd_ok = 1'b1;
`endif

  // r_drop parks a rejected access until both strobes are released
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cap        <= 16'h0000;
      r_addr       <= 7'h00;
      r_addr_valid <= 1'b0;
      r_drop       <= 1'b0;
      SDOut        <= 16'h0000;
      SDOe         <= 1'b0;
      busErr       <= 1'b0;
    end else begin
      busErr <= 1'b0;
      if (!WRN) r_cap <= SDIn;
      if (r_drop) begin
        if (WRN && RDN) r_drop <= 1'b0;
      end else if (w_proto_err) begin
        busErr  <= 1'b1;
        r_drop  <= 1'b1;
        SDOe    <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (!WRN) begin
              if (CMD) begin
                r_state <= ST_CMDW;
              end else if (r_addr_valid) begin
                r_state <= ST_DATW;
              end else begin
                busErr <= 1'b1;
                r_drop <= 1'b1;
              end
            end else if (!RDN) begin
              if (r_addr_valid) begin
                r_state <= ST_DATR;
                SDOe    <= 1'b1;
                SDOut   <= w_rdata;
              end else begin
                busErr <= 1'b1;
                r_drop <= 1'b1;
              end
            end
          end
          ST_CMDW: begin
            if (WRN) begin
              r_state <= ST_IDLE;
              if (w_cmd_ok) begin
                r_addr       <= r_cap[7:1];
                r_addr_valid <= 1'b1;
              end else begin
                busErr       <= 1'b1;
                r_addr_valid <= 1'b0;
              end
            end
          end
          ST_DATW: begin
            if (WRN) r_state <= ST_IDLE;
          end
          ST_DATR: begin
            if (RDN) begin
              r_state <= ST_IDLE;
              SDOe    <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ksz_resp_regfile u_regfile (
    .clk40m    (clk40m),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (r_addr),
    .i_wdata   (r_cap),
    .i_raddr   (r_addr),
    .o_rdata   (w_rdata),
    .i_irq_set (irqSet),
    .o_intrn   (INTRN)
  );

endmodule

// File: tb/tb_ksz_bus_responder.sv
// Directed plus randomized bench for ksz_bus_responder.
// Reference model: a plain word array with CIDER/ISR rules applied.
module tb_ksz_bus_responder;

  logic        clk40m = 1'b0;
  logic        reset  = 1'b0;
  logic        CMD    = 1'b0;
  logic        WRN    = 1'b1;
  logic        RDN    = 1'b1;
  logic [15:0] SDIn   = 16'h0000;
  logic [15:0] irqSet = 16'h0000;
  logic [15:0] SDOut;
  logic        SDOe;
  logic        INTRN;
  logic        busErr;

  int checks = 0;
  int errors = 0;
  int berr_seen = 0;
  int exp_berr = 0;
  logic [15:0] mem [128];

  ksz_bus_responder dut (
    .clk40m (clk40m),
    .reset  (reset),
    .CMD    (CMD),
    .WRN    (WRN),
    .RDN    (RDN),
    .SDIn   (SDIn),
    .SDOut  (SDOut),
    .SDOe   (SDOe),
    .irqSet (irqSet),
    .INTRN  (INTRN),
    .busErr (busErr)
  );

  always #5 clk40m = ~clk40m;

  always @(negedge clk40m) if (busErr === 1'b1) berr_seen++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [6:0] a);
    return (a == 7'h60) ? 16'h8872 : mem[a];
  endfunction

  function automatic void model_write(input logic [6:0] a,
                                      input logic [15:0] d);
    if (a == 7'h49) mem[a] = mem[a] & ~d;
    else if (a != 7'h60) mem[a] = d;
  endfunction

  function automatic logic model_intrn();
    return ~|(mem[7'h49] & mem[7'h48]);
  endfunction

  function automatic logic [15:0] mk_cmd(input logic [6:0] a);
    logic [3:0] be;
    be = a[0] ? 4'hC : 4'h3;
    return {be, 4'($urandom), a, 1'($urandom)};
  endfunction

  task automatic wr_phase(input logic c, input logic [15:0] v);
    @(negedge clk40m);
    CMD = c; WRN = 1'b0; SDIn = v;
    @(negedge clk40m);
    @(negedge clk40m);
    WRN = 1'b1; SDIn = 16'($urandom);
    @(negedge clk40m);
    CMD = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] cmd, input logic [15:0] exp,
                         input string tag);
    wr_phase(1'b1, cmd);
    @(negedge clk40m);
    RDN = 1'b0; CMD = 1'b0;
    @(negedge clk40m);
    chk({tag, "_oe"}, SDOe, 1'b1);
    chk({tag, "_data"}, SDOut, exp);
    @(negedge clk40m);
    chk({tag, "_hold"}, SDOut, exp);
    RDN = 1'b1;
    @(negedge clk40m);
    chk({tag, "_oe_off"}, SDOe, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk40m);
    reset = 1'b0;
    @(negedge clk40m);
    reset = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
  endtask

  logic [6:0]  a, a2;
  logic [15:0] d;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    #2;
    chk("rst_sdout", SDOut, 16'h0000);
    chk("rst_sdoe", SDOe, 1'b0);
    chk("rst_buserr", busErr, 1'b0);
    chk("rst_intrn", INTRN, 1'b1);
    @(negedge clk40m);
    reset = 1'b1;

    // data write with no command since reset
    @(negedge clk40m);
    CMD = 1'b0; WRN = 1'b0; SDIn = 16'hBEEF;
    @(negedge clk40m);
    chk("nocmd_berr_hi", busErr, 1'b1);
    @(negedge clk40m);
    chk("nocmd_berr_lo", busErr, 1'b0);
    WRN = 1'b1;
    exp_berr++;
    do_read(16'h3000, 16'h0000, "nocmd_word0");

    do_read(16'h30C0, 16'h8872, "cider");

    wr_phase(1'b1, 16'h3010); wr_phase(1'b0, 16'h89AB);
    wr_phase(1'b1, 16'hC012); wr_phase(1'b0, 16'h4567);
    do_read(16'hC012, 16'h4567, "marm");
    do_read(16'h3010, 16'h89AB, "marl");
    wr_phase(1'b1, 16'h30C0); wr_phase(1'b0, 16'h1111);
    do_read(16'h30C0, 16'h8872, "cider_ro");
    #2 chk("berr_after_wr", berr_seen, exp_berr);

    // interrupt path
    wr_phase(1'b1, 16'h3090); wr_phase(1'b0, 16'h2000);
    chk("ier_only_intrn", INTRN, 1'b1);
    @(negedge clk40m); irqSet = 16'h2000;
    @(negedge clk40m); irqSet = 16'h0000;
    chk("irq_set_intrn", INTRN, 1'b0);
    wr_phase(1'b1, 16'hC092); wr_phase(1'b0, 16'hFFFF);
    chk("isr_clr_intrn", INTRN, 1'b1);
    @(negedge clk40m); irqSet = 16'h2000;
    @(negedge clk40m); irqSet = 16'h0000;
    chk("irq_set2_intrn", INTRN, 1'b0);
    wr_phase(1'b1, 16'hC092);
    irqSet = 16'h2000;
    wr_phase(1'b0, 16'hFFFF);
    irqSet = 16'h0000;
    chk("set_wins_intrn", INTRN, 1'b0);
    do_read(16'hC092, 16'h2000, "isr_rd");

    // byte-enable pairing
    wr_phase(1'b1, 16'hC010);
    wr_phase(1'b0, 16'hDEAD);
`ifdef KSZ_RESP_STRICT_BE_EN
    exp_berr += 2;
    do_read(16'h3010, 16'h89AB, "strict_reject");
`else
    do_read(16'h3010, 16'hDEAD, "loose_accept");
`endif
    #2 chk("berr_be", berr_seen, exp_berr);

    // reset during a read
    wr_phase(1'b1, 16'h3070); wr_phase(1'b0, 16'h1234);
    wr_phase(1'b1, 16'h3070);
    @(negedge clk40m); RDN = 1'b0;
    @(negedge clk40m);
    chk("pre_rst_oe", SDOe, 1'b1);
    chk("pre_rst_data", SDOut, 16'h1234);
    #2 reset = 1'b0;
    #1 chk("midrst_oe", SDOe, 1'b0);
    chk("midrst_sdout", SDOut, 16'h0000);
    @(negedge clk40m);
    RDN = 1'b1; reset = 1'b1;
    do_read(16'h3070, 16'h0000, "txcr_after_rst");

    apply_reset();
    for (int k = 0; k < 24; k++) begin
      a = 7'($urandom_range(0, 127));
      d = 16'($urandom);
      wr_phase(1'b1, mk_cmd(a));
      wr_phase(1'b0, d);
      model_write(a, d);
      chk("rnd_intrn", INTRN, model_intrn());
      do_read(mk_cmd(a), model_read(a), "rnd_same");
      a2 = (k % 3 == 0) ? 7'h60 : 7'($urandom_range(0, 127));
      do_read(mk_cmd(a2), model_read(a2), "rnd_any");
    end

    #2 chk("berr_total", berr_seen, exp_berr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ksz_bus_responder.md
KSZ_BUS_RESPONDER -- requirements
Module: ksz_bus_responder

Interface
REQ-001 SHALL have port clk40m, input, 1 bit: single clock; all state is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port CMD, input, 1 bit: 1 = command (address) phase, 0 = data phase.
REQ-004 SHALL have port WRN, input, 1 bit: active-low write strobe.
REQ-005 SHALL have port RDN, input, 1 bit: active-low read strobe.
REQ-006 SHALL have port SDIn, input, 16 bits: bus data from the initiator.
REQ-007 SHALL have port SDOut, output, 16 bits: read data.
REQ-008 SHALL have port SDOe, output, 1 bit: 1 = responder drives the bus.
REQ-009 SHALL have port irqSet, input, 16 bits: per-bit event pulses into ISR.
REQ-010 SHALL have port INTRN, output, 1 bit: active-low interrupt, equal to ~|(ISR & IER).
REQ-011 SHALL have port busErr, output, 1 bit: one-cycle protocol-error pulse.

Function
REQ-012 SHALL decode the command word as: bits[15:12] = byte enables, bits[7:1] = word address (128 words); bits[11:8] and bit[0] are ignored.
REQ-013 SHALL implement states IDLE, CMDW, DATW, DATR: IDLE->CMDW on WRN=0 & CMD=1; IDLE->DATW on WRN=0 & CMD=0; IDLE->DATR on RDN=0 & CMD=0; CMDW/DATW->IDLE on WRN=1; DATR->IDLE on RDN=1.
REQ-014 SHALL continuously capture SDIn while in CMDW or DATW, so the value committed is the one present in the last cycle before WRN rises.
REQ-015 SHALL, on WRN rising from CMDW, latch the word address and byte enables and set addrValid.
REQ-016 SHALL, on WRN rising from DATW, commit the captured data to the latched word address and keep addrValid set.
REQ-017 SHALL, on the first clock edge at which RDN=0 & CMD=0 is sampled, register SDOe=1 and SDOut=reg[addr], i.e. data is valid 1 cycle after RDN is sampled low, and hold both until RDN=1 is sampled.
REQ-018 SHALL clear SDOe in the cycle after RDN=1 is sampled.
REQ-019 SHALL pulse busErr and ignore the access when any of the following occurs: a data phase with addrValid=0; WRN and RDN both low; or RDN low while CMD=1.
REQ-020 SHALL treat word 0x60 (byte address 0xC0, CIDER) as read-only with value 16'h8872; writes to it are dropped without error.
REQ-021 SHALL treat word 0x49 (byte address 0x92, ISR) as write-1-to-clear; each cycle, bits set in irqSet are ORed in, and when set and clear coincide on the same bit, set wins.
REQ-022 SHALL treat every other word as plain read/write storage.
REQ-023 SHALL make a read of a word that is being written in the same cycle return the old value.

Reset
REQ-024 SHALL, while reset=0, force: SDOut=0, SDOe=0, busErr=0, INTRN=1, state=IDLE, addrValid=0, and all storage=0 except CIDER.
REQ-025 SHALL abort any access in progress when reset is asserted mid-access; no partial commit is made and SDOe drops immediately.

Configuration
REQ-026 SHALL, when KSZ_RESP_STRICT_BE_EN is defined, accept only BE=4'h3 with an even word address and BE=4'hC with an odd word address; any other command SHALL pulse busErr and clear addrValid.
REQ-027 SHALL, when KSZ_RESP_STRICT_BE_EN is not defined, ignore byte enables entirely.

Structure
REQ-028 SHALL take from package ksz_bus_pkg: the state enum, the CHIP_ID constant, and the byte-address constants (CIDER, MARL/M/H, TXCR, RXCR1, RXCR2, RXQCR, RXFDPR, RXFCTR, IER, ISR, P1CR).
REQ-029 SHALL place storage, CIDER handling and ISR handling in the sub-module ksz_resp_regfile; the bus state machine stays in the top level.

Verification
REQ-030 SHALL cover: after reset, command 30C0 followed by a 2-cycle read -> SDOut=8872 and SDOe=1 one cycle after RDN is sampled low.
REQ-031 SHALL cover: write 3010/89AB, then C012/4567, then read back C012 -> SDOut=4567, busErr never pulses.
REQ-032 SHALL cover: irqSet=0x2000 while IER=0x2000 -> INTRN=0; write C092/FFFF -> INTRN=1; a coincident irqSet=0x2000 during that write -> INTRN stays 0.
REQ-033 SHALL cover: a data write with no prior command after reset -> busErr pulses for 1 cycle and storage is unchanged.
REQ-034 SHALL cover: reset asserted while RDN=0 -> SDOe=0 immediately; a subsequent read of 3070 returns 0.
REQ-035 SHALL cover, with KSZ_RESP_STRICT_BE_EN defined: command C010 -> busErr pulses and the following data write is rejected.
